// File: rtl/draw_timing.sv
`default_nettype none
// ============================================================================
// Module   : draw_timing
// Purpose  : Raster timing generator producing pixel/line counters, blanking,
//            sync, frame-start pulse and frame counter, all registered.
// Revision : 1.0 - initial release
// ============================================================================
module draw_timing #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        frame_start,
    output logic [7:0]  frame_cnt
);

    localparam int C_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int C_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] C_H_LAST     = 11'(C_H_TOTAL - 1);
    localparam logic [10:0] C_H_ACT      = 11'(H_ACTIVE);
    localparam logic [10:0] C_HS_FIRST   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] C_HS_LAST    = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  C_V_LAST     = 10'(C_V_TOTAL - 1);
    localparam logic [9:0]  C_V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0]  C_VS_FIRST   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  C_VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [10:0] hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic        hblnk_q, hblnk_d;
    logic        vblnk_q, vblnk_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        fstart_q, fstart_d;
    logic [7:0]  fcnt_q, fcnt_d;

    // Flags are derived from the next counts so they land in the same cycle
    // as the position they describe.
    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        fstart_d = 1'b0;
        if (en) begin
            if (hcount_q == C_H_LAST) begin
                hcount_d = '0;
                if (vcount_q == C_V_LAST) begin
                    vcount_d = '0;
                    fstart_d = 1'b1;
                end else begin
                    vcount_d = vcount_q + 10'd1;
                end
            end else begin
                hcount_d = hcount_q + 11'd1;
            end
        end
        fcnt_d  = fstart_d ? fcnt_q + 8'd1 : fcnt_q;
        hblnk_d = (hcount_d >= C_H_ACT);
        vblnk_d = (vcount_d >= C_V_ACT);
        hsync_d = ((hcount_d >= C_HS_FIRST) && (hcount_d <= C_HS_LAST)) ? SYNC_POL : ~SYNC_POL;
        vsync_d = ((vcount_d >= C_VS_FIRST) && (vcount_d <= C_VS_LAST)) ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount_q <= '0;
            vcount_q <= '0;
            hblnk_q  <= 1'b0;
            vblnk_q  <= 1'b0;
            hsync_q  <= ~SYNC_POL;
            vsync_q  <= ~SYNC_POL;
            fstart_q <= 1'b0;
            fcnt_q   <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hblnk_q  <= hblnk_d;
            vblnk_q  <= vblnk_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            fstart_q <= fstart_d;
            fcnt_q   <= fcnt_d;
        end
    end

    assign hcount_out  = hcount_q;
    assign vcount_out  = vcount_q;
    assign hblnk_out   = hblnk_q;
    assign vblnk_out   = vblnk_q;
    assign hsync_out   = hsync_q;
    assign vsync_out   = vsync_q;
    assign frame_start = fstart_q;
    assign frame_cnt   = fcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_draw_timing.sv
`default_nettype none
// ============================================================================
// Module   : tb_draw_timing
// Purpose  : Self-checking bench for draw_timing using a reduced raster and a
//            linear-pixel-index reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_draw_timing;

    localparam int HA = 10, HFP = 2, HS = 3, HBP = 2;
    localparam int VA = 5,  VFP = 1, VS = 2, VBP = 2;
    localparam bit POL = 1'b0;
    localparam int HT = HA + HFP + HS + HBP;   // 17
    localparam int VT = VA + VFP + VS + VBP;   // 10
    localparam int FRAME = HT * VT;            // 170

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic        hblnk_out, vblnk_out, hsync_out, vsync_out, frame_start;
    logic [7:0]  frame_cnt;

    int checks   = 0;
    int failures = 0;

    draw_timing #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(POL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .hcount_out (hcount_out),
        .vcount_out (vcount_out),
        .hblnk_out  (hblnk_out),
        .vblnk_out  (vblnk_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .frame_start(frame_start),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: position is a single index into the frame.
    int m_p   = 0;
    int m_cnt = 0;
    bit m_fs  = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_p   = 0;
            m_cnt = 0;
            m_fs  = 1'b0;
        end else if (en) begin
            m_p  = (m_p + 1) % FRAME;
            m_fs = (m_p == 0);
            if (m_fs) m_cnt = (m_cnt + 1) % 256;
        end else begin
            m_fs = 1'b0;
        end
    end

    always @(negedge clk) begin
        int h, v;
        h = m_p % HT;
        v = m_p / HT;
        chk("hcount", int'(hcount_out), h);
        chk("vcount", int'(vcount_out), v);
        chk("hblnk", int'(hblnk_out), int'(h >= HA));
        chk("vblnk", int'(vblnk_out), int'(v >= VA));
        chk("hsync", int'(hsync_out), int'((h >= HA + HFP && h < HA + HFP + HS) ? POL : !POL));
        chk("vsync", int'(vsync_out), int'((v >= VA + VFP && v < VA + VFP + VS) ? POL : !POL));
        chk("frame_start", int'(frame_start), int'(m_fs));
        chk("frame_cnt", int'(frame_cnt), m_cnt);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Advance until the DUT shows the requested position/count (-1 = any).
    task automatic run_until(input int h, input int v, input int c, input int budget);
        int n = 0;
        while (!((h < 0 || int'(hcount_out) == h) && (v < 0 || int'(vcount_out) == v) &&
                 (c < 0 || int'(frame_cnt) == c))) begin
            if (n >= budget) begin
                chk("run_until_timeout", n, -1);
                return;
            end
            step();
            n++;
        end
    endtask

    initial begin
        int pulses, first_pulse, second_pulse, hs_low, hb_high, vs_low, cnt_before;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_hcount", int'(hcount_out), 0);
        chk("rst_vcount", int'(vcount_out), 0);
        chk("rst_hsync", int'(hsync_out), 1);
        chk("rst_vsync", int'(vsync_out), 1);
        chk("rst_blank", int'({hblnk_out, vblnk_out}), 0);
        chk("rst_fcnt", int'(frame_cnt), 0);

        rst = 1'b1;
        en  = 1'b1;
        step();
        chk("first_h", int'(hcount_out), 1);
        chk("first_v", int'(vcount_out), 0);
        chk("first_fs", int'(frame_start), 0);

        // Two complete frames from position 1.
        pulses = 0; first_pulse = 0; second_pulse = 0; hs_low = 0; hb_high = 0; vs_low = 0;
        for (int i = 1; i <= 2 * FRAME; i++) begin
            step();
            if (i < HT) begin
                hs_low  += int'(hsync_out == 1'b0);
                hb_high += int'(hblnk_out);
            end
            if (i <= FRAME) vs_low += int'(vsync_out == 1'b0);
            if (frame_start) begin
                pulses++;
                if (pulses == 1) first_pulse = i; else second_pulse = i;
                chk("pulse_at_origin", int'(hcount_out) + int'(vcount_out), 0);
            end
        end
        chk("pulse_count", pulses, 2);
        chk("first_pulse_cycle", first_pulse, FRAME - 1);
        chk("pulse_spacing", second_pulse - first_pulse, FRAME);
        chk("fcnt_two", int'(frame_cnt), 2);
        chk("hsync_width", hs_low, HS);
        chk("hblnk_width", hb_high, HT - HA);
        chk("vsync_cycles", vs_low, VS * HT);

        // Asynchronous reset mid-frame with frame_cnt at 7.
        run_until(5, 3, 7, 8 * FRAME);
        rst = 1'b0;
        #1;
        chk("arst_hcount", int'(hcount_out), 0);
        chk("arst_vcount", int'(vcount_out), 0);
        chk("arst_fcnt", int'(frame_cnt), 0);
        chk("arst_sync", int'({hsync_out, vsync_out}), 3);
        chk("arst_fs", int'(frame_start), 0);
        step();
        step();
        rst = 1'b1;
        step();
        chk("rel_h", int'(hcount_out), 1);
        chk("rel_v", int'(vcount_out), 0);
        chk("rel_fcnt", int'(frame_cnt), 0);

        // Stall on the last pixel of the frame.
        run_until(HT - 1, VT - 1, -1, 2 * FRAME);
        cnt_before = int'(frame_cnt);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_h", int'(hcount_out), HT - 1);
            chk("hold_v", int'(vcount_out), VT - 1);
            chk("hold_fs", int'(frame_start), 0);
            chk("hold_blank", int'({hblnk_out, vblnk_out}), 3);
        end
        en = 1'b1;
        step();
        chk("resume_h", int'(hcount_out), 0);
        chk("resume_v", int'(vcount_out), 0);
        chk("resume_fs", int'(frame_start), 1);
        chk("resume_fcnt", int'(frame_cnt), (cnt_before + 1) % 256);

        // Random enable pattern.
        for (int i = 0; i < 2000; i++) begin
            en = ($urandom_range(0, 3) != 0);
            step();
        end

        // Frame counter roll-over.
        en = 1'b1;
        run_until(-1, -1, 255, 260 * FRAME);
        run_until(0, 0, 0, 2 * FRAME);
        chk("wrap_fs", int'(frame_start), 1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/draw_timing.md
DRAW_TIMING -- requirements
Module: draw_timing

Interface
REQ-001 Parameter H_ACTIVE, 1024, visible pixels per line.
REQ-002 Parameter H_FP, 24, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 136, horizontal sync width in pixels.
REQ-004 Parameter H_BP, 160, horizontal back porch in pixels (H_TOTAL = 1344).
REQ-005 Parameter V_ACTIVE, 768, visible lines per frame.
REQ-006 Parameter V_FP, 3, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 6, vertical sync width in lines.
REQ-008 Parameter V_BP, 29, vertical back porch in lines (V_TOTAL = 806).
REQ-009 Parameter SYNC_POL, 0, sync polarity during the sync interval: 0 = low, 1 = high.
REQ-010 clk  input  1  65 MHz pixel clock; all state SHALL change on its rising edge only.
REQ-011 rst  input  1  asynchronous, active-low reset.
REQ-012 en  input  1  count enable; when high, the timing advances one pixel per clock.
REQ-013 hcount_out  output  11  current pixel column, 0..H_TOTAL-1.
REQ-014 vcount_out  output  10  current line, 0..V_TOTAL-1.
REQ-015 hblnk_out  output  1  high when hcount_out >= H_ACTIVE.
REQ-016 vblnk_out  output  1  high when vcount_out >= V_ACTIVE.
REQ-017 hsync_out  output  1  horizontal sync at SYNC_POL level inside the sync window.
REQ-018 vsync_out  output  1  vertical sync at SYNC_POL level inside the sync window.
REQ-019 frame_start  output  1  one-cycle pulse when the counters wrap to (0,0).
REQ-020 frame_cnt  output  8  number of completed frames, modulo 256.

Function
REQ-021 All outputs SHALL be registered; no output SHALL be a combinational function of an input.
REQ-022 All outputs SHALL describe the same pixel in the same cycle.
- Blank, sync and pulse flags are computed from the next counter values and registered together with those counts.
- Zero skew between hcount_out and any flag.
REQ-023 Horizontal counting when en=1:
- hcount_out increments by 1 per clock.
- At H_TOTAL-1 (1343) it wraps to 0.
REQ-024 Vertical counting:
- vcount_out increments only on the horizontal wrap.
- On the horizontal wrap with vcount_out = V_TOTAL-1 (805), it wraps to 0.
REQ-025 hsync_out SHALL be at SYNC_POL for hcount_out in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [1048,1183], and at !SYNC_POL otherwise.
REQ-026 vsync_out SHALL be at SYNC_POL for vcount_out in [771,776], for every hcount_out on those lines, and at !SYNC_POL otherwise.
REQ-027 The blank windows SHALL be exactly:
- hblnk_out high for hcount_out 1024..1343.
- vblnk_out high for vcount_out 768..805.
REQ-028 frame_start SHALL be 1 for exactly the one cycle in which the outputs first show (0,0) after the (1343,805) position, and 0 otherwise.
REQ-029 frame_cnt SHALL increment in the same cycle that frame_start is high, wrapping from 255 to 0.
REQ-030 When en=0, every output SHALL hold its value, except frame_start, which SHALL be 0.
- Resuming en=1 continues from the held position.
- The held position is not re-entered: no repeated or skipped pixel.
REQ-031 If en falls in the cycle where a wrap would occur, the wrap, frame_start and the frame_cnt increment SHALL be deferred to the next enabled cycle.
REQ-032 Counter arithmetic SHALL use full 11-bit and 10-bit widths; the counters never exceed H_TOTAL-1 or V_TOTAL-1.

Reset
REQ-033 While rst=0, all outputs SHALL be forced immediately, regardless of clk:
- hcount_out=0, vcount_out=0, hblnk_out=0, vblnk_out=0.
- hsync_out=!SYNC_POL, vsync_out=!SYNC_POL.
- frame_start=0, frame_cnt=0.
REQ-034 On the first enabled rising edge after rst rises, the position SHALL advance to (1,0).
- No frame_start is generated for the reset position (0,0).
REQ-035 Asserting rst mid-line or mid-frame SHALL abandon the current frame with no partial pulse on any output.

Verification
REQ-036 Release reset with en=1 and run 1344 clocks -> hcount_out sequence 1..1343 then 0, vcount_out goes 0->1 on the wrap, frame_start stays 0.
REQ-037 Run two full frames (2 x 1083264 clocks) -> frame_start pulses exactly twice, 1083264 clocks apart, frame_cnt 0->1->2, each pulse coincident with (0,0).
REQ-038 Scan one line with SYNC_POL=0 -> hsync_out low for exactly 136 cycles starting at hcount_out=1048; hblnk_out high for exactly 320 cycles starting at hcount_out=1024.
REQ-039 Scan one frame -> vsync_out low on exactly lines 771..776 (8064 cycles); vblnk_out high on exactly lines 768..805.
REQ-040 Drop en for 5 cycles at (1343,805) -> all outputs frozen and frame_start=0 throughout; on the first enabled edge the outputs show (0,0) with frame_start=1.
REQ-041 Assert rst asynchronously at (500,300), mid-cycle, with frame_cnt=7 -> outputs reach reset values before the next clk edge; after release the count restarts at (1,0) with frame_cnt=0.
